exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter IDX_W, default 4, width of the element index and beat counter (16 vector elements).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr_valid  input  1  decoded instruction fields below are valid this cycle.
REQ-005 functype  input  4  opcode from decode (VADD 0000, VDOT 0001, SMUL 0010, SST 0011, VLD 0100, VST 0101, SLL 0110, SLH 0111, NOP 1111).
REQ-006 cycle_count  input  IDX_W  decode beat count; memory ops run cycle_count+1 beats.
REQ-007 v_en  input  1  instruction writes the vector register file.
REQ-008 s_en  input  1  instruction writes the scalar register file.
REQ-009 mem_ready  input  1  memory accepts the current beat.
REQ-010 instr_ready  output  1  sequencer can accept an instruction (high only in IDLE).
REQ-011 busy  output  1  FSM not in IDLE.
REQ-012 mem_req  output  1  memory beat request.
REQ-013 mem_we  output  1  beat is a store (VST).
REQ-014 elem_idx  output  IDX_W  element index of the current memory beat.
REQ-015 vrf_we  output  1  vector register file write strobe.
REQ-016 wb_idx  output  IDX_W  element index for vrf_we.
REQ-017 srf_we  output  1  scalar register file write strobe.
REQ-018 done  output  1  one-cycle pulse: instruction retired.
REQ-019 illegal  output  1  sticky flag: undefined opcode (1000-1110) accepted.

Function
REQ-020 States SHALL be IDLE, EXEC, MEM, WB, FIN; transfer occurs when instr_valid && instr_ready, latching functype, cycle_count, v_en, s_en.
REQ-021 IDLE: on transfer of VLD/VST -> MEM with elem_idx=0; any other opcode -> EXEC; else stay.
REQ-022 EXEC (one cycle): vrf_we=latched v_en, srf_we=latched s_en, wb_idx=0, done=1; NOP and undefined opcodes assert no write strobe; -> IDLE.
REQ-023 Undefined opcode transfer SHALL set illegal, which stays 1 until reset.
REQ-024 MEM: mem_req=1, mem_we=1 for VST else 0; elem_idx holds while mem_ready=0 (no timeout).
REQ-025 MEM, mem_ready=1 and elem_idx<latched count: elem_idx increments by 1.
REQ-026 MEM, mem_ready=1 and elem_idx==latched count: VLD -> WB, VST -> FIN; elem_idx never wraps (count 15 gives beats 0..15; count 0 gives one beat).
REQ-027 VLD: the cycle after each accepted beat k, vrf_we=1 and wb_idx=k (1-cycle read latency); last element's write occurs in WB.
REQ-028 WB (one cycle): vrf_we=1, wb_idx=latched count, done=1, mem_req=0; -> IDLE.
REQ-029 FIN (one cycle): done=1, no strobes, mem_req=0; -> IDLE.
REQ-030 VST SHALL never assert vrf_we or srf_we.
REQ-031 instr_ready is combinational (state==IDLE); back-to-back: next instruction accepted the cycle after done.
REQ-032 All other outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path except none.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, busy=0, mem_req=0, mem_we=0, elem_idx=0, vrf_we=0, wb_idx=0, srf_we=0, done=0, illegal=0, regardless of state.
REQ-034 Reset mid-MEM abandons the instruction; no done or write strobe for it after release.
REQ-035 No transfer occurs while rst_n is low; first transfer possible on the first rising edge after release.

Verification
REQ-036 VADD (functype 0000, v_en=1) transfer at cycle 0 -> cycle 1: vrf_we=1, wb_idx=0, done=1; cycle 2: instr_ready=1.
REQ-037 VLD, cycle_count=15, mem_ready=1 always -> mem_req for 16 cycles, elem_idx 0..15; vrf_we wb_idx 0..14 delayed one cycle; WB writes 15 with done; 18 cycles transfer-to-IDLE.
REQ-038 VST, cycle_count=3, mem_ready toggling 1,0,1,0... -> mem_we=1, each index held through stall cycles, indices 0..3, FIN done, zero vrf_we/srf_we.
REQ-039 SLL (0110, s_en=1) then NOP (1111) back-to-back -> srf_we on first EXEC only; two done pulses two cycles apart; NOP produces no strobe.
REQ-040 Functype 1010 -> illegal=1, done pulse, no strobes; illegal stays 1 through later VADD; clears only on rst_n low.
REQ-041 rst_n low during VLD beat 7 -> all outputs 0 asynchronously; after release instr_ready=1, no done for aborted VLD.

Source files
------------

// File: rtl/exec_sequencer_if.sv
// Instruction-decode and memory-beat signal bundle for exec_sequencer.
// The slave modport is the sequencer side; the master modport is the
// decode/memory environment that drives it.
interface exec_sequencer_if #(
    parameter int IDX_W = 4
) ();
    // Instruction handshake from decode
    logic             instr_valid;
    logic [3:0]       functype;
    logic [IDX_W-1:0] cycle_count;
    logic             v_en;
    logic             s_en;
    logic             instr_ready;

    // Memory beat handshake
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic [IDX_W-1:0] elem_idx;

    // Register file write-back and status
    logic             vrf_we;
    logic [IDX_W-1:0] wb_idx;
    logic             srf_we;
    logic             busy;
    logic             done;
    logic             illegal;

    modport slave (
        input  instr_valid, functype, cycle_count, v_en, s_en, mem_ready,
        output instr_ready, busy, mem_req, mem_we, elem_idx,
               vrf_we, wb_idx, srf_we, done, illegal
    );

    modport master (
        output instr_valid, functype, cycle_count, v_en, s_en, mem_ready,
        input  instr_ready, busy, mem_req, mem_we, elem_idx,
               vrf_we, wb_idx, srf_we, done, illegal
    );
endinterface

// File: rtl/exec_sequencer.sv
// Execution sequencer: accepts one decoded instruction at a time, runs
// single-cycle execute for register ops, or a multi-beat memory sequence
// for VLD/VST, and emits register-file write strobes and a retire pulse.
// Every output except instr_ready/busy is a register; those two are decoded
// from the registered state only.
module exec_sequencer #(
    parameter int IDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    exec_sequencer_if.slave   bus
);

    typedef enum logic [3:0] {
        OP_VADD = 4'b0000,
        OP_VDOT = 4'b0001,
        OP_SMUL = 4'b0010,
        OP_SST  = 4'b0011,
        OP_VLD  = 4'b0100,
        OP_VST  = 4'b0101,
        OP_SLL  = 4'b0110,
        OP_SLH  = 4'b0111,
        OP_NOP  = 4'b1111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_MEM  = 3'd2,
        ST_WB   = 3'd3,
        ST_FIN  = 3'd4
    } state_e;

    // Opcodes 1000..1110 are unassigned; 1111 is NOP and is legal.
    function automatic logic is_undefined(input logic [3:0] op);
        return (op[3] == 1'b1) && (op != OP_NOP);
    endfunction

    // Only defined, non-NOP register ops may raise a write strobe in EXEC.
    function automatic logic exec_may_write(input logic [3:0] op);
        return (!is_undefined(op)) && (op != OP_NOP);
    endfunction

    state_e           state_r;
    logic [3:0]       op_r;
    logic [IDX_W-1:0] cnt_r;
    logic             v_en_r;
    logic             s_en_r;

    logic             mem_req_r;
    logic             mem_we_r;
    logic [IDX_W-1:0] elem_idx_r;
    logic             vrf_we_r;
    logic [IDX_W-1:0] wb_idx_r;
    logic             srf_we_r;
    logic             done_r;
    logic             illegal_r;

    logic             idle_s;
    logic             transfer_s;
    logic             last_beat_s;

    assign idle_s      = (state_r == ST_IDLE);
    assign transfer_s  = bus.instr_valid && idle_s;
    assign last_beat_s = (elem_idx_r == cnt_r);

    // Sequencer FSM with all registered outputs updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            op_r       <= 4'b0000;
            cnt_r      <= {IDX_W{1'b0}};
            v_en_r     <= 1'b0;
            s_en_r     <= 1'b0;
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            elem_idx_r <= {IDX_W{1'b0}};
            vrf_we_r   <= 1'b0;
            wb_idx_r   <= {IDX_W{1'b0}};
            srf_we_r   <= 1'b0;
            done_r     <= 1'b0;
            illegal_r  <= 1'b0;
        end else begin
            // Strobes and the retire pulse are single-cycle unless re-armed below.
            vrf_we_r <= 1'b0;
            srf_we_r <= 1'b0;
            done_r   <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (transfer_s) begin
                        op_r   <= bus.functype;
                        cnt_r  <= bus.cycle_count;
                        v_en_r <= bus.v_en;
                        s_en_r <= bus.s_en;
                        if ((bus.functype == OP_VLD) || (bus.functype == OP_VST)) begin
                            state_r    <= ST_MEM;
                            mem_req_r  <= 1'b1;
                            mem_we_r   <= (bus.functype == OP_VST);
                            elem_idx_r <= {IDX_W{1'b0}};
                        end else begin
                            // Register op: the EXEC cycle shows the strobes and retires.
                            state_r  <= ST_EXEC;
                            done_r   <= 1'b1;
                            wb_idx_r <= {IDX_W{1'b0}};
                            if (exec_may_write(bus.functype)) begin
                                vrf_we_r <= bus.v_en;
                                srf_we_r <= bus.s_en;
                            end else begin
                                vrf_we_r <= 1'b0;
                                srf_we_r <= 1'b0;
                            end
                            if (is_undefined(bus.functype)) begin
                                illegal_r <= 1'b1;
                            end else begin
                                illegal_r <= illegal_r;
                            end
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_EXEC: begin
                    state_r <= ST_IDLE;
                end

                ST_MEM: begin
                    if (bus.mem_ready) begin
                        // Load data returns one cycle after the beat is accepted,
                        // so the write for beat k lands on the following cycle.
                        if (op_r == OP_VLD) begin
                            vrf_we_r <= 1'b1;
                            wb_idx_r <= elem_idx_r;
                        end else begin
                            vrf_we_r <= 1'b0;
                        end
                        if (last_beat_s) begin
                            // Index stays at the count: no wrap after beat 15.
                            mem_req_r <= 1'b0;
                            mem_we_r  <= 1'b0;
                            done_r    <= 1'b1;
                            state_r   <= (op_r == OP_VLD) ? ST_WB : ST_FIN;
                        end else begin
                            elem_idx_r <= elem_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        // Stall: hold the beat indefinitely until memory accepts it.
                        state_r <= ST_MEM;
                    end
                end

                ST_WB: begin
                    state_r <= ST_IDLE;
                end

                ST_FIN: begin
                    state_r <= ST_IDLE;
                end

                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instr_ready = idle_s;
    assign bus.busy        = !idle_s;
    assign bus.mem_req     = mem_req_r;
    assign bus.mem_we      = mem_we_r;
    assign bus.elem_idx    = elem_idx_r;
    assign bus.vrf_we      = vrf_we_r;
    assign bus.wb_idx      = wb_idx_r;
    assign bus.srf_we      = srf_we_r;
    assign bus.done        = done_r;
    assign bus.illegal     = illegal_r;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: drives on the falling edge, checks
// registered outputs on the falling edge after each rising edge.
module tb_exec_sequencer;

    localparam int IDX_W = 4;

    localparam logic [3:0] F_VADD = 4'b0000;
    localparam logic [3:0] F_VLD  = 4'b0100;
    localparam logic [3:0] F_VST  = 4'b0101;
    localparam logic [3:0] F_SLL  = 4'b0110;
    localparam logic [3:0] F_NOP  = 4'b1111;
    localparam logic [3:0] F_UND  = 4'b1010;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    exec_sequencer_if #(.IDX_W(IDX_W)) bus ();

    exec_sequencer #(.IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] op, input logic [IDX_W-1:0] cnt,
                         input logic v, input logic s);
        bus.instr_valid = 1'b1;
        bus.functype    = op;
        bus.cycle_count = cnt;
        bus.v_en        = v;
        bus.s_en        = s;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.mem_ready = 1'b0;

        // ---- reset holds off a pending VADD ----
        issue(F_VADD, 4'd0, 1'b1, 1'b0);
        tick(); tick();
        chk("rst_busy",    32'(bus.busy),        32'd0);
        chk("rst_ready",   32'(bus.instr_ready), 32'd1);
        chk("rst_mem_req", 32'(bus.mem_req),     32'd0);
        chk("rst_mem_we",  32'(bus.mem_we),      32'd0);
        chk("rst_elem",    32'(bus.elem_idx),    32'd0);
        chk("rst_vrf",     32'(bus.vrf_we),      32'd0);
        chk("rst_wbidx",   32'(bus.wb_idx),      32'd0);
        chk("rst_srf",     32'(bus.srf_we),      32'd0);
        chk("rst_done",    32'(bus.done),        32'd0);
        chk("rst_illegal", 32'(bus.illegal),     32'd0);

        // ---- VADD transferred on first edge after release ----
        rst_n = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        chk("vadd_vrf",   32'(bus.vrf_we),      32'd1);
        chk("vadd_wbidx", 32'(bus.wb_idx),      32'd0);
        chk("vadd_done",  32'(bus.done),        32'd1);
        chk("vadd_srf",   32'(bus.srf_we),      32'd0);
        chk("vadd_busy",  32'(bus.busy),        32'd1);
        chk("vadd_nrdy",  32'(bus.instr_ready), 32'd0);
        tick();
        chk("vadd_ready", 32'(bus.instr_ready), 32'd1);
        chk("vadd_done0", 32'(bus.done),        32'd0);
        chk("vadd_vrf0",  32'(bus.vrf_we),      32'd0);

        // ---- VLD, 16 beats, memory always ready ----
        bus.mem_ready = 1'b1;
        issue(F_VLD, 4'd15, 1'b1, 1'b0);
        tick();
        bus.instr_valid = 1'b0;
        chk("vld_req0",  32'(bus.mem_req),  32'd1);
        chk("vld_idx0",  32'(bus.elem_idx), 32'd0);
        chk("vld_vrf0",  32'(bus.vrf_we),   32'd0);
        chk("vld_we0",   32'(bus.mem_we),   32'd0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("vld_req",   32'(bus.mem_req),  32'd1);
            chk("vld_idx",   32'(bus.elem_idx), 32'(k));
            chk("vld_vrf",   32'(bus.vrf_we),   32'd1);
            chk("vld_wbidx", 32'(bus.wb_idx),   32'(k - 1));
            chk("vld_done",  32'(bus.done),     32'd0);
        end
        tick();
        chk("vld_wb_req",  32'(bus.mem_req), 32'd0);
        chk("vld_wb_vrf",  32'(bus.vrf_we),  32'd1);
        chk("vld_wb_idx",  32'(bus.wb_idx),  32'd15);
        chk("vld_wb_done", 32'(bus.done),    32'd1);
        chk("vld_wb_srf",  32'(bus.srf_we),  32'd0);
        tick();
        chk("vld_idle_rdy",  32'(bus.instr_ready), 32'd1);
        chk("vld_idle_busy", 32'(bus.busy),        32'd0);
        chk("vld_idle_done", 32'(bus.done),        32'd0);

        // ---- VLD single beat, stalled three cycles first ----
        bus.mem_ready = 1'b0;
        issue(F_VLD, 4'd0, 1'b1, 1'b0);
        tick();
        bus.instr_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk("vld1_req",  32'(bus.mem_req),  32'd1);
            chk("vld1_idx",  32'(bus.elem_idx), 32'd0);
            chk("vld1_vrf",  32'(bus.vrf_we),   32'd0);
            tick();
        end
        chk("vld1_req_st", 32'(bus.mem_req), 32'd1);
        bus.mem_ready = 1'b1;
        tick();
        chk("vld1_wb_vrf",  32'(bus.vrf_we),  32'd1);
        chk("vld1_wb_idx",  32'(bus.wb_idx),  32'd0);
        chk("vld1_wb_done", 32'(bus.done),    32'd1);
        chk("vld1_wb_req",  32'(bus.mem_req), 32'd0);
        tick();
        chk("vld1_ready", 32'(bus.instr_ready), 32'd1);

        // ---- VST, 4 beats, mem_ready toggling 1,0,1,0... ----
        issue(F_VST, 4'd3, 1'b1, 1'b1);
        tick();
        bus.instr_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            bus.mem_ready = (c % 2 == 1);
            chk("vst_req",  32'(bus.mem_req),  32'd1);
            chk("vst_we",   32'(bus.mem_we),   32'd1);
            chk("vst_idx",  32'(bus.elem_idx), 32'(c / 2));
            chk("vst_vrf",  32'(bus.vrf_we),   32'd0);
            chk("vst_srf",  32'(bus.srf_we),   32'd0);
            chk("vst_done", 32'(bus.done),     32'd0);
            tick();
        end
        chk("vst_fin_done", 32'(bus.done),    32'd1);
        chk("vst_fin_req",  32'(bus.mem_req), 32'd0);
        chk("vst_fin_we",   32'(bus.mem_we),  32'd0);
        chk("vst_fin_vrf",  32'(bus.vrf_we),  32'd0);
        chk("vst_fin_srf",  32'(bus.srf_we),  32'd0);
        tick();
        chk("vst_ready", 32'(bus.instr_ready), 32'd1);

        // ---- SLL then NOP back-to-back ----
        bus.mem_ready = 1'b0;
        issue(F_SLL, 4'd0, 1'b0, 1'b1);
        tick();
        chk("sll_srf",  32'(bus.srf_we), 32'd1);
        chk("sll_vrf",  32'(bus.vrf_we), 32'd0);
        chk("sll_done", 32'(bus.done),   32'd1);
        issue(F_NOP, 4'd0, 1'b1, 1'b1);
        tick();
        chk("gap_done",  32'(bus.done),        32'd0);
        chk("gap_srf",   32'(bus.srf_we),      32'd0);
        chk("gap_ready", 32'(bus.instr_ready), 32'd1);
        tick();
        bus.instr_valid = 1'b0;
        chk("nop_done", 32'(bus.done),   32'd1);
        chk("nop_srf",  32'(bus.srf_we), 32'd0);
        chk("nop_vrf",  32'(bus.vrf_we), 32'd0);
        tick();
        chk("nop_idle", 32'(bus.done), 32'd0);

        // ---- undefined opcode sets sticky illegal ----
        issue(F_UND, 4'd0, 1'b1, 1'b1);
        tick();
        bus.instr_valid = 1'b0;
        chk("und_illegal", 32'(bus.illegal), 32'd1);
        chk("und_done",    32'(bus.done),    32'd1);
        chk("und_vrf",     32'(bus.vrf_we),  32'd0);
        chk("und_srf",     32'(bus.srf_we),  32'd0);
        tick();
        chk("und_sticky", 32'(bus.illegal), 32'd1);
        issue(F_VADD, 4'd0, 1'b1, 1'b0);
        tick();
        bus.instr_valid = 1'b0;
        chk("und_vadd_vrf",  32'(bus.vrf_we),  32'd1);
        chk("und_vadd_ill",  32'(bus.illegal), 32'd1);
        tick();

        // ---- reset during VLD beat 7 ----
        bus.mem_ready = 1'b1;
        issue(F_VLD, 4'd15, 1'b1, 1'b0);
        tick();
        bus.instr_valid = 1'b0;
        repeat (7) tick();
        chk("abort_idx7", 32'(bus.elem_idx), 32'd7);
        chk("abort_req7", 32'(bus.mem_req),  32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",    32'(bus.busy),        32'd0);
        chk("arst_ready",   32'(bus.instr_ready), 32'd1);
        chk("arst_req",     32'(bus.mem_req),     32'd0);
        chk("arst_elem",    32'(bus.elem_idx),    32'd0);
        chk("arst_vrf",     32'(bus.vrf_we),      32'd0);
        chk("arst_wbidx",   32'(bus.wb_idx),      32'd0);
        chk("arst_done",    32'(bus.done),        32'd0);
        chk("arst_illegal", 32'(bus.illegal),     32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_done",  32'(bus.done),        32'd0);
            chk("post_vrf",   32'(bus.vrf_we),      32'd0);
            chk("post_req",   32'(bus.mem_req),     32'd0);
            chk("post_ready", 32'(bus.instr_ready), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
